dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares one single-port data memory between N_CORES processor cores in the multi-core build.
- Each core's dm_en/ar_out/bus_out path becomes a request port on this block.
- Arbitration is round-robin. Exactly one access is in flight at a time.
- A per-core one-cycle ack marks write completion or read-data valid. Read data is returned on a shared rdata bus.

Parameters:
N_CORES, 4, number of requesting cores (2..8)
ADDR_W, 12, data-memory address width
DATA_W, 12, data-memory word width
RD_LAT, 1, memory read latency in cycles from address edge to mem_rdata valid (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req  in  N_CORES  per-core access request; held with we/addr/wdata stable until ack
we  in  N_CORES  per-core write enable (1=write, 0=read), sampled with req
addr  in  N_CORES*ADDR_W  per-core address, core i at bits [i*ADDR_W +: ADDR_W]
wdata  in  N_CORES*DATA_W  per-core write data, same packing
ack  out  N_CORES  one-cycle completion pulse to granted core
rdata  out  DATA_W  registered read data, valid when ack[i]=1 for a read
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, sel=0, rr_ptr=0, wait_cnt=0, rdata=0.
- Outputs during reset: ack=0, mem_en=0, mem_we=0, busy=0. mem_addr/mem_wdata are don't-care.
- mem_en and mem_we are gated by !rst, so no write occurs on a reset edge.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req bit is set, sel = first index with req=1 searching from rr_ptr upward, wrapping modulo N_CORES.
  - Latch we_q=we[sel]; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1, mem_we=we_q, mem_addr=addr[sel], mem_wdata=wdata[sel], all combinational from the registered sel.
  - Write: go to ACK.
  - Read: wait_cnt=RD_LAT-1; go to WAIT.
- WAIT:
  - mem_en=0.
  - If wait_cnt==0: rdata<=mem_rdata; go to ACK. Otherwise decrement wait_cnt.
- ACK (exactly 1 cycle):
  - ack[sel]=1, all other ack bits 0.
  - rr_ptr <= (sel+1) mod N_CORES; go to IDLE.
- Latency, with req sampled at edge k:
  - Write: memory written at edge k+1; ack high in cycle k+1..k+2.
  - Read: ack and rdata valid in cycle k+1+RD_LAT.
  - Repeated back-to-back write throughput: 3 cycles; read throughput: 3+RD_LAT cycles.
- Requester rule: drop req (or present a new access) on the edge where ack is seen. IDLE re-evaluates one cycle later, so there is no double grant.
- rdata holds its value until the next read completes; writes do not alter it.
- req changes on the granted core after IDLE are ignored; the access completes with the latched sel/we_q. addr/wdata must remain stable through ISSUE.
- Requests from non-granted cores are held pending and never dropped. Round-robin guarantees service within N_CORES transactions.
- Reset mid-transaction aborts it. No ack is issued, and the requester must re-request.

Optional Feature:
- Macro DM_ARB_HOST_PRIO_EN.
  - Defined: in IDLE, req[0] (host/loader port) wins unconditionally. Other cores use round-robin among themselves, and rr_ptr is not updated on a core-0 grant.
  - Undefined: pure round-robin over all ports, as described above.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> busy=0, ack=0, mem_en=0, rdata=0. First grant after release goes to core 0.
- Single write: core 2 writes addr=0x0A5, wdata=0x3C1 at edge k -> mem_en=mem_we=1 with addr 0x0A5 in cycle k; ack=4'b0100 in cycle k+1; a later read of 0x0A5 returns rdata=0x3C1.
- Read latency: RD_LAT=1 then RD_LAT=3, core 1 reads preloaded 0x7FF at addr 0x010 -> ack[1] exactly 2 and 4 cycles after the req edge, rdata=0x7FF.
- Round-robin: req=4'b1111 held, each core dropping req after its ack -> grant order 0,1,2,3. Re-raising all gives 0,1,2,3 again, with no core granted twice before the others.
- Hold/ignore: core 3 busy on a read while core 0 pulses req low mid-WAIT -> core 3 completes normally; core 0 is granted only when it re-asserts.
- Reset mid-op: rst asserted in the ISSUE cycle of a write to 0x020 -> memory at 0x020 unchanged, no ack, state IDLE. With DM_ARB_HOST_PRIO_EN defined and req=4'b1110 pending plus req[0] rising -> core 0 is granted next.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing one single-port data memory among N_CORES cores.
// Define DM_ARB_HOST_PRIO_EN to give core 0 (host/loader) absolute priority in IDLE.
module dm_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES-1:0]        we,
  input  logic [N_CORES*ADDR_W-1:0] addr,
  input  logic [N_CORES*DATA_W-1:0] wdata,
  output logic [N_CORES-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);
  localparam int SW = N_CORES > 1 ? $clog2(N_CORES) : 1;
  localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, ACK = 2'd3;
  logic [1:0]         r_state;
  logic [SW-1:0]      r_sel, r_rr_ptr, w_pick;
  logic [SW:0]        w_idx;
  logic [CW-1:0]      r_wait_cnt;
  logic               r_we_q;
  logic [DATA_W-1:0]  r_rdata;
  logic [N_CORES-1:0] w_req;
  // Descending scan so the request closest to rr_ptr is written last and wins.
  always_comb begin
`ifdef DM_ARB_HOST_PRIO_EN
    w_req = req & {{(N_CORES-1){1'b1}}, 1'b0};
`else
    w_req = req;
`endif
    w_pick = '0;
    w_idx = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_rr_ptr} + (SW+1)'(i);
      if (w_idx >= (SW+1)'(N_CORES)) w_idx = w_idx - (SW+1)'(N_CORES);
      if (w_req[w_idx[SW-1:0]]) w_pick = w_idx[SW-1:0];
    end
`ifdef DM_ARB_HOST_PRIO_EN
    if (req[0]) w_pick = '0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_rr_ptr   <= '0;
      r_wait_cnt <= '0;
      r_we_q     <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: if (|req) begin
          r_sel   <= w_pick;
          r_we_q  <= we[w_pick];
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_wait_cnt <= CW'(RD_LAT - 1);
          r_state    <= r_we_q ? ACK : WAIT;
        end
        WAIT: if (r_wait_cnt == '0) begin
          r_rdata <= mem_rdata;
          r_state <= ACK;
        end else begin
          r_wait_cnt <= r_wait_cnt - 1'b1;
        end
        default: begin
`ifdef DM_ARB_HOST_PRIO_EN
          if (r_sel != '0)
`endif
          r_rr_ptr <= r_sel == SW'(N_CORES - 1) ? '0 : r_sel + 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end
  assign busy      = !rst && r_state != IDLE;
  assign mem_en    = !rst && r_state == ISSUE;
  assign mem_we    = mem_en && r_we_q;
  assign mem_addr  = addr[r_sel*ADDR_W +: ADDR_W];
  assign mem_wdata = wdata[r_sel*DATA_W +: DATA_W];
  assign ack       = (!rst && r_state == ACK) ? N_CORES'(1) << r_sel : '0;
  assign rdata     = r_rdata;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter; main instance RD_LAT=1, second instance RD_LAT=3.
`timescale 1ns/1ps
module tb_dm_arbiter;
  localparam int N = 4;
`ifdef DM_ARB_HOST_PRIO_EN
  localparam int HC = 1;
`else
  localparam int HC = 0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0, we = '0, req3 = '0, ack, ack3;
  logic [11:0] a_arr [N], d_arr [N];
  logic [N*12-1:0] addr, wdata;
  logic [11:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [11:0] rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic mem_en, mem_we, busy, mem_en3, mem_we3, busy3;
  logic [11:0] mem [4096], mem3 [4096], p3 [3];
  int cyc = 0, n_chk = 0, n_pass = 0;
  typedef struct {int core; bit rd; int dat; int k; int lat;} exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign addr  = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign wdata = {d_arr[3], d_arr[2], d_arr[1], d_arr[0]};

  dm_arbiter u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  dm_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(4'b0000), .addr({12'h0, 12'h0, 12'h010, 12'h0}),
    .wdata(48'h0), .ack(ack3), .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory models: 1-cycle synchronous RAM and a 3-stage read pipeline.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
    p3[0] <= (mem_en3 && !mem_we3) ? mem3[mem_addr3] : p3[0];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input int c, input bit w, input int a, input int d);
    we[c]    = w;
    a_arr[c] = 12'(a);
    d_arr[c] = 12'(d);
    req[c]   = 1'b1;
  endtask

  task automatic expect_op(input int c, input bit rd, input int dat, input int lat);
    sbq.push_back('{c, rd, dat, cyc + 1, lat});
  endtask

  task automatic drain(input int budget);
    exp_t e;
    int n = 0;
    while (sbq.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (ack != '0) begin
        e = sbq.pop_front();
        chk($sformatf("ack_core%0d", e.core), 32'(ack), 32'(1) << e.core);
        if (e.rd) chk($sformatf("rdata_core%0d", e.core), 32'(rdata), e.dat);
        if (e.lat >= 0) chk($sformatf("latency_core%0d", e.core), cyc - e.k, e.lat);
        req = req & ~ack;
      end
    end
    chk("sb_drained", sbq.size(), 0);
    sbq.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int acc, t0;
    bit seen;
    mem[12'h010]  = 12'h7FF;
    mem[12'h020]  = 12'h155;
    mem3[12'h010] = 12'h7FF;
    for (int i = 0; i < N; i++) drive(i, 1'b1, 'h100 + i, 'h200 + i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) expect_op(i, 1'b0, 0, -1);
    drain(40);
    for (int i = 0; i < N; i++) begin
      drive(i, 1'b0, 'h100 + i, 0);
      expect_op(i, 1'b1, 'h200 + i, -1);
    end
    drain(40);
    drive(2, 1'b1, 'h0A5, 'h3C1);
    expect_op(2, 1'b0, 0, 1);
    @(negedge clk);
    chk("iss_en", mem_en, 1);
    chk("iss_we", mem_we, 1);
    chk("iss_addr", mem_addr, 'h0A5);
    chk("iss_wdata", mem_wdata, 'h3C1);
    drain(10);
    drive(0, 1'b0, 'h0A5, 0);
    expect_op(0, 1'b1, 'h3C1, 2);
    drain(10);
    drive(1, 1'b0, 'h010, 0);
    expect_op(1, 1'b1, 'h7FF, 2);
    drain(10);
    req3[1] = 1'b1;
    t0 = cyc + 1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (ack3 != '0) begin
        seen = 1'b1;
        chk("lat3_ack", ack3, 4'b0010);
        chk("lat3_latency", cyc - t0, 4);
        chk("lat3_rdata", rdata3, 'h7FF);
        req3 = '0;
      end
    end
    chk("lat3_seen", seen, 1);
    @(negedge clk);
    // Core 3 wins (rr_ptr=2); the other core drops its request mid-WAIT.
    drive(3, 1'b0, 'h020, 0);
    drive(HC, 1'b0, 'h0A5, 0);
    expect_op(3, 1'b1, 'h155, 2);
    repeat (2) @(negedge clk);
    req[HC] = 1'b0;
    drain(10);
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      acc = acc | int'(ack);
    end
    chk("no_ghost_ack", acc, 0);
    chk("idle_busy", busy, 0);
    drive(HC, 1'b0, 'h0A5, 0);
    expect_op(HC, 1'b1, 'h3C1, 2);
    drain(10);
    drive(1, 1'b1, 'h030, 'h111);
    expect_op(1, 1'b0, 0, 1);
    drain(10);
    chk("rdata_hold", rdata, 'h3C1);
    drive(1, 1'b1, 'h020, 'hABC);
    @(negedge clk);
    chk("abort_iss_en", mem_en, 1);
    rst = 1'b1;
    #1 chk("abort_en_gated", mem_en, 0);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    chk("abort_rdata", rdata, 0);
    req[1] = 1'b0;
    rst = 1'b0;
    chk("abort_mem", mem[12'h020], 'h155);
    drive(2, 1'b0, 'h020, 0);
    expect_op(2, 1'b1, 'h155, 2);
    drain(10);
`ifdef DM_ARB_HOST_PRIO_EN
    for (int i = 1; i < N; i++) drive(i, 1'b0, 'h100 + i, 0);
    expect_op(3, 1'b1, 'h203, -1);
    drain(10);
    @(negedge clk);
    drive(0, 1'b0, 'h100, 0);
    expect_op(1, 1'b1, 'h201, -1);
    expect_op(0, 1'b1, 'h200, -1);
    expect_op(2, 1'b1, 'h202, -1);
    drain(30);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
